stream_product_packer: RTL and testbench

- Parametrised successor to the basic two-operand data processing unit.
- Accepts operand pairs over a valid/ready stream and applies a selectable arithmetic op (multiply, add, subtract, multiply-accumulate), signed or unsigned.
- Packs DEPTH results into one wide output word, held under output backpressure.
- Supports flushing a partial frame with an element count; sits between operand producers and downstream vector consumers.

---
 rtl/stream_product_packer.sv | 144 ++++++++++++++
 tb/tb_stream_product_packer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_product_packer.sv
// Applies mul/add/sub/MAC to operand pairs and packs DEPTH results per frame; frame is valid 1 cycle after its last accept.
// A stalled output frame stops intake only at the last slot; a pending flush stops intake until it is emitted.
module stream_product_packer #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int RW    = 2 * WIDTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      data_in1,
  input  logic [WIDTH-1:0]      data_in2,
  input  logic [1:0]            op_mode,
  input  logic                  signed_mode,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RW*DEPTH-1:0]   out_data,
  output logic [CW-1:0]         out_count
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_MAC = 2'b11
  } op_e;

  op_e                         op_q, op_d, eff_op;
  logic                        sgn_q, sgn_d, eff_sgn;
  logic [IW-1:0]               idx_q, idx_d;
  logic [RW-1:0]               acc_q, acc_d;
  logic [DEPTH-1:0][RW-1:0]    buf_q, buf_d, frame;
  logic                        pend_q, pend_d;
  logic                        out_valid_q, out_valid_d;
  logic [RW*DEPTH-1:0]         out_data_q, out_data_d;
  logic [CW-1:0]               out_count_q, out_count_d;

  logic                        accept, last, full_load, flush_now, part_load, out_free;
  logic [RW-1:0]               a_ext, b_ext, prod, acc_base, res;

  always_comb begin
    in_ready = !rst && !pend_q &&
               (!(out_valid_q && !out_ready) || (idx_q != IW'(DEPTH - 1)));
    accept   = in_valid && in_ready;
    last     = (idx_q == IW'(DEPTH - 1));
    out_free = !out_valid_q || out_ready;

    // Mode comes straight from the inputs on the first beat so that beat uses it too.
    eff_op  = (idx_q == '0) ? op_e'(op_mode) : op_q;
    eff_sgn = (idx_q == '0) ? signed_mode    : sgn_q;

    a_ext = eff_sgn ? {{WIDTH{data_in1[WIDTH-1]}}, data_in1} : {{WIDTH{1'b0}}, data_in1};
    b_ext = eff_sgn ? {{WIDTH{data_in2[WIDTH-1]}}, data_in2} : {{WIDTH{1'b0}}, data_in2};
    prod  = a_ext * b_ext;
    acc_base = (idx_q == '0) ? '0 : acc_q;

    case (eff_op)
      OP_MUL:  res = prod;
      OP_ADD:  res = a_ext + b_ext;
      OP_SUB:  res = a_ext - b_ext;
      OP_MAC:  res = acc_base + prod;
      default: res = prod;
    endcase

    // Slots past the fill point read as zero, so stale buffer contents never leak.
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (idx_q == IW'(i)))
        frame[i] = res;
      else if (IW'(i) < idx_q)
        frame[i] = buf_q[i];
      else
        frame[i] = '0;
    end

    full_load = accept && last;
    flush_now = flush && ((idx_q != '0) || accept) && !full_load;
    part_load = (pend_q || flush_now) && out_free && !full_load;

    idx_d  = idx_q;
    acc_d  = acc_q;
    buf_d  = buf_q;
    op_d   = op_q;
    sgn_d  = sgn_q;
    pend_d = (pend_q || flush_now) && !part_load;

    if (accept) begin
      buf_d[idx_q] = res;
      idx_d        = last ? '0 : idx_q + 1'b1;
      if (eff_op == OP_MAC)
        acc_d = res;
      if (idx_q == '0) begin
        op_d  = eff_op;
        sgn_d = eff_sgn;
      end
    end
    if (part_load)
      idx_d = '0;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (full_load || part_load) begin
      out_valid_d = 1'b1;
      out_data_d  = frame;
      out_count_d = CW'(idx_q) + CW'(accept);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_MUL;
      sgn_q       <= 1'b0;
      idx_q       <= '0;
      acc_q       <= '0;
      buf_q       <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      op_q        <= op_d;
      sgn_q       <= sgn_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      buf_q       <= buf_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_stream_product_packer.sv
// Bench for stream_product_packer: directed frames plus randomized traffic against a frame-level reference model.
module tb_stream_product_packer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int RW = 16;
  localparam int CW = 3;

  localparam logic [63:0] MUL_PAT = 64'h0038_001E_000C_0002;
  localparam logic [63:0] MAC_PAT = 64'h0064_002C_000E_0002;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      data_in1;
  logic [W-1:0]      data_in2;
  logic [1:0]        op_mode;
  logic              signed_mode;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [RW*D-1:0]   out_data;
  logic [CW-1:0]     out_count;

  stream_product_packer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in1    (data_in1),
    .data_in2    (data_in2),
    .op_mode     (op_mode),
    .signed_mode (signed_mode),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_count   (out_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: collects the operand pairs of a frame and evaluates it with integer arithmetic.
  typedef struct {
    logic [63:0] data;
    int          cnt;
  } frame_t;

  frame_t       exp_q[$];
  int           m_cnt = 0;
  logic [7:0]   m_a[D];
  logic [7:0]   m_b[D];
  logic [1:0]   m_op;
  logic         m_sgn;

  function automatic longint ext(input logic [7:0] v, input logic s);
    return (s && v[7]) ? longint'(v) - 256 : longint'(v);
  endfunction

  function automatic logic [63:0] model_frame(input int n);
    longint      acc = 0;
    longint      va, vb, r;
    logic [63:0] d = '0;
    for (int k = 0; k < n; k++) begin
      va = ext(m_a[k], m_sgn);
      vb = ext(m_b[k], m_sgn);
      case (m_op)
        2'd0:    r = va * vb;
        2'd1:    r = va + vb;
        2'd2:    r = va - vb;
        default: begin acc = acc + va * vb; r = acc; end
      endcase
      d[16*k +: 16] = r[15:0];
    end
    return d;
  endfunction

  task automatic push_frame();
    frame_t f;
    f.data = model_frame(m_cnt);
    f.cnt  = m_cnt;
    exp_q.push_back(f);
    m_cnt = 0;
  endtask

  // Inputs only change just after a rising edge, so the falling edge sees what the next edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_frame", {63'd0, out_valid}, 64'd0);
        end else begin
          check_eq("sb_data", out_data, exp_q[0].data);
          check_eq("sb_count", {61'd0, out_count}, exp_q[0].cnt);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        if (m_cnt == 0) begin
          m_op  = op_mode;
          m_sgn = signed_mode;
        end
        m_a[m_cnt] = data_in1;
        m_b[m_cnt] = data_in2;
        m_cnt++;
        if (m_cnt == D) push_frame();
        else if (flush) push_frame();
      end else if (flush && m_cnt > 0) begin
        push_frame();
      end
    end
  end

  // Offer one beat and return just after the edge that accepts it.
  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                      input logic sg, input logic fl);
    int n = 0;
    data_in1    = a;
    data_in2    = b;
    op_mode     = op;
    signed_mode = sg;
    flush       = fl;
    in_valid    = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check_eq("beat_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic frame4(input logic [1:0] op, input logic [63:0] exp, input string tag);
    for (int k = 0; k < 4; k++) beat(8'(2*k+1), 8'(2*k+2), op, 1'b0, 1'b0);
    check_eq({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
    check_eq({tag, "_dat"}, out_data, exp);
    check_eq({tag, "_cnt"}, {61'd0, out_count}, 64'd4);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; data_in1 = '0; data_in2 = '0; op_mode = '0;
    signed_mode = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_vld", {63'd0, out_valid}, 64'd0);
    check_eq("rst_dat", out_data, 64'd0);
    check_eq("rst_cnt", {61'd0, out_count}, 64'd0);
    check_eq("rst_rdy", {63'd0, in_ready}, 64'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_rdy", {63'd0, in_ready}, 64'd1);
    next_cycle();

    // Unsigned multiply; output must appear right after the 4th accept.
    for (int k = 0; k < 3; k++) beat(8'(2*k+1), 8'(2*k+2), 2'd0, 1'b0, 1'b0);
    check_eq("mul_early_vld", {63'd0, out_valid}, 64'd0);
    beat(8'd7, 8'd8, 2'd0, 1'b0, 1'b0);
    check_eq("mul_vld", {63'd0, out_valid}, 64'd1);
    check_eq("mul_dat", out_data, MUL_PAT);
    check_eq("mul_cnt", {61'd0, out_count}, 64'd4);
    next_cycle();
    check_eq("mul_drop", {63'd0, out_valid}, 64'd0);

    frame4(2'd3, MAC_PAT, "mac1");
    next_cycle();
    frame4(2'd3, MAC_PAT, "mac2");
    next_cycle();

    // Single-beat flushed frames exercise extension rules.
    beat(8'hFF, 8'h02, 2'd0, 1'b1, 1'b1);
    check_eq("smul_dat", out_data, 64'h0000_0000_0000_FFFE);
    check_eq("smul_cnt", {61'd0, out_count}, 64'd1);
    next_cycle();
    beat(8'hFF, 8'h02, 2'd0, 1'b0, 1'b1);
    check_eq("umul_dat", out_data, 64'h0000_0000_0000_01FE);
    next_cycle();
    beat(8'h00, 8'h01, 2'd2, 1'b0, 1'b1);
    check_eq("usub_dat", out_data, 64'h0000_0000_0000_FFFF);
    next_cycle();

    for (int k = 0; k < 4; k++) beat(8'(2*k+1), 8'(2*k+2), 2'(k), 1'b0, 1'b0);
    check_eq("latch_dat", out_data, MUL_PAT);
    next_cycle();

    // Backpressure: frame 1 held, beats 5-7 buffered, beat 8 stalls.
    out_ready = 1'b0;
    frame4(2'd0, MUL_PAT, "bp1");
    for (int k = 0; k < 3; k++) beat(8'(2*k+1), 8'(2*k+2), 2'd0, 1'b0, 1'b0);
    data_in1 = 8'd7; data_in2 = 8'd8; op_mode = 2'd0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("bp_stall_rdy", {63'd0, in_ready}, 64'd0);
      check_eq("bp_hold_dat", out_data, MUL_PAT);
      check_eq("bp_hold_vld", {63'd0, out_valid}, 64'd1);
    end
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_rdy", {63'd0, in_ready}, 64'd1);
    next_cycle();
    in_valid = 1'b0;
    check_eq("bp2_vld", {63'd0, out_valid}, 64'd1);
    check_eq("bp2_dat", out_data, MUL_PAT);
    check_eq("bp2_cnt", {61'd0, out_count}, 64'd4);
    next_cycle();
    check_eq("bp2_drop", {63'd0, out_valid}, 64'd0);

    // Flush variants.
    beat(8'd1, 8'd2, 2'd0, 1'b0, 1'b0);
    beat(8'd3, 8'd4, 2'd0, 1'b0, 1'b0);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    check_eq("fl2_vld", {63'd0, out_valid}, 64'd1);
    check_eq("fl2_dat", out_data, 64'h0000_0000_000C_0002);
    check_eq("fl2_cnt", {61'd0, out_count}, 64'd2);
    next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("fl0_vld", {63'd0, out_valid}, 64'd0);
      next_cycle();
    end
    for (int k = 0; k < 3; k++) beat(8'(2*k+1), 8'(2*k+2), 2'd0, 1'b0, 1'b0);
    beat(8'd7, 8'd8, 2'd0, 1'b0, 1'b1);
    check_eq("fl4_dat", out_data, MUL_PAT);
    check_eq("fl4_cnt", {61'd0, out_count}, 64'd4);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      check_eq("fl4_no_extra", {63'd0, out_valid}, 64'd0);
    end

    // Reset mid-frame, with the previous frame still sitting in the output register.
    for (int k = 0; k < 3; k++) beat(8'd9, 8'd9, 2'd1, 1'b0, 1'b0);
    rst = 1'b1;
    next_cycle();
    check_eq("mrst_vld", {63'd0, out_valid}, 64'd0);
    check_eq("mrst_dat", out_data, 64'd0);
    check_eq("mrst_cnt", {61'd0, out_count}, 64'd0);
    check_eq("mrst_rdy", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    next_cycle();
    frame4(2'd0, MUL_PAT, "clean");
    next_cycle();

    // Randomized traffic, checked by the model.
    repeat (3000) begin
      in_valid    = ($urandom % 4) != 0;
      data_in1    = 8'($urandom);
      data_in2    = 8'($urandom);
      op_mode     = 2'($urandom);
      signed_mode = 1'($urandom);
      flush       = ($urandom % 12) == 0;
      out_ready   = ($urandom % 3) != 0;
      next_cycle();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    next_cycle();
    flush = 1'b0;
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    next_cycle();
    check_eq("drain_idle", {63'd0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
